msfsm_fire_scheduler: RTL and testbench

Transition-firing scheduler for a synchronous multi-FSM (MSFSM) network. Accepts per-transition requests from the environment and picks at most one enabled, requested transition per decision. Emits a one-cycle, one-hot fire pulse that drives the network's shared transition inputs `t0..t(NT-1)`, then waits a settle window so the FSMs' state-synchronisation outputs are current before the next decision. Sits between the environment handshakes and the `msfsms_mealy` network, enforcing interleaving semantics and resolving free-choice conflicts fairly.

---
 rtl/msfsm_fire_scheduler_if.sv | 15 +
 rtl/msfsm_fire_scheduler.sv | 139 +++++++++++++
 tb/tb_msfsm_fire_scheduler.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/msfsm_fire_scheduler_if.sv
// Handshake bundle between the environment (master) and the fire scheduler (slave).
// Carries per-transition request/enable inputs and fire/ack/status outputs.
interface msfsm_fire_scheduler_if #(
  parameter int NT = 8
);
  logic [NT-1:0] req;
  logic [NT-1:0] en;
  logic [NT-1:0] fire;
  logic [NT-1:0] ack;
  logic          busy;
  logic          deadlock;

  modport master (output req, en, input fire, ack, busy, deadlock);
  modport slave  (input req, en, output fire, ack, busy, deadlock);
endinterface

// File: rtl/msfsm_fire_scheduler.sv
// Round-robin, one-hot transition-firing scheduler for an MSFSM network with a settle window.
// Optional deadlock detector is built only when MSFSM_SCHED_DEADLOCK_EN is defined.
module msfsm_fire_scheduler #(
  parameter int NT            = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int DL_LIMIT      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  msfsm_fire_scheduler_if.slave bus
);
  localparam int PW = (NT > 1) ? $clog2(NT) : 1;

  typedef enum logic [1:0] {IDLE, FIRE, SETTLE} state_e;

  if (NT < 2 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 || DL_LIMIT < 1 || DL_LIMIT > 255)
  begin : g_bad_cfg
    $error("msfsm_fire_scheduler: parameter out of range");
  end

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [3:0]    settle_q, settle_d;
  logic [NT-1:0] fire_q, fire_d;
  logic [NT-1:0] ack_q, ack_d;

  logic [NT-1:0] elig;
  logic          found;
  logic [PW-1:0] grant_idx;

  assign elig = bus.req & ~ack_q & bus.en;

  // Scan from the highest offset down so the closest set bit at or above ptr wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = NT - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NT;
      if (elig[idx]) begin
        found     = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    settle_d = settle_q;
    fire_d   = fire_q;
    ack_d    = ack_q & bus.req;
    case (state_q)
      IDLE: begin
        if (found) begin
          fire_d            = '0;
          fire_d[grant_idx] = 1'b1;
          ack_d[grant_idx]  = 1'b1;
          ptr_d             = (grant_idx == PW'(NT - 1)) ? '0 : grant_idx + 1'b1;
          state_d           = FIRE;
        end
      end
      FIRE: begin
        fire_d   = '0;
        settle_d = 4'(SETTLE_CYCLES - 1);
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      default: begin
        fire_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      settle_q <= '0;
      fire_q   <= '0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      settle_q <= settle_d;
      fire_q   <= fire_d;
      ack_q    <= ack_d;
    end
  end

  assign bus.fire = fire_q;
  assign bus.ack  = ack_q;
  assign bus.busy = (state_q != IDLE);

`ifdef MSFSM_SCHED_DEADLOCK_EN
  logic [7:0] dl_cnt_q, dl_cnt_d;
  logic       deadlock_q, deadlock_d;
  logic       blocked;

  // Blocked: someone is waiting, but nothing they asked for is enabled.
  assign blocked = (state_q == IDLE) && (|(bus.req & ~ack_q)) && !found;

  always_comb begin
    dl_cnt_d   = '0;
    deadlock_d = deadlock_q;
    if (blocked) begin
      dl_cnt_d = (dl_cnt_q == 8'hFF) ? 8'hFF : dl_cnt_q + 8'd1;
    end
    if (dl_cnt_d >= 8'(DL_LIMIT)) begin
      deadlock_d = 1'b1;
    end
    if (state_q == IDLE && found) begin
      deadlock_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dl_cnt_q   <= '0;
      deadlock_q <= 1'b0;
    end else begin
      dl_cnt_q   <= dl_cnt_d;
      deadlock_q <= deadlock_d;
    end
  end

  assign bus.deadlock = deadlock_q;
`else
  assign bus.deadlock = 1'b0;
`endif
endmodule

// File: tb/tb_msfsm_fire_scheduler.sv
// Directed-vector bench for msfsm_fire_scheduler; each task drives one scenario and checks inline.
module tb_msfsm_fire_scheduler;
  localparam int NT = 8;
`ifdef MSFSM_SCHED_DEADLOCK_EN
  localparam logic DL_EN = 1'b1;
`else
  localparam logic DL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  msfsm_fire_scheduler_if #(.NT(NT)) bus ();

  msfsm_fire_scheduler #(.NT(NT), .SETTLE_CYCLES(1), .DL_LIMIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    bus.en  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.req = 8'hFF;
    bus.en  = 8'hFF;
    tick();
    tick();
    tick();
    checks++;
    if (bus.fire !== 8'h00) begin errors++; $display("FAIL reset_fire: got %h expected 00", bus.fire); end
    checks++;
    if (bus.ack !== 8'h00) begin errors++; $display("FAIL reset_ack: got %h expected 00", bus.ack); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.deadlock !== 1'b0) begin errors++; $display("FAIL reset_deadlock: got %b expected 0", bus.deadlock); end
    reset = 1'b0;
    checks++;
    if (bus.fire !== 8'h00) begin errors++; $display("FAIL reset_release_fire0: got %h expected 00", bus.fire); end
    tick();
    checks++;
    if (bus.fire !== 8'h01) begin errors++; $display("FAIL reset_first_fire: got %h expected 01", bus.fire); end
    $display("test_reset: fire after release %h", bus.fire);
  endtask

  task automatic test_single_fire();
    do_reset();
    bus.req = 8'h01;
    bus.en  = 8'h01;
    tick();
    checks++;
    if (bus.fire !== 8'h01 || bus.ack !== 8'h01 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_c1: fire %h ack %h busy %b expected 01 01 1", bus.fire, bus.ack, bus.busy);
    end
    tick();
    checks++;
    if (bus.fire !== 8'h00 || bus.ack !== 8'h01 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_c2: fire %h ack %h busy %b expected 00 01 1", bus.fire, bus.ack, bus.busy);
    end
    tick();
    checks++;
    if (bus.fire !== 8'h00 || bus.ack !== 8'h01 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL single_c3: fire %h ack %h busy %b expected 00 01 0", bus.fire, bus.ack, bus.busy);
    end
    tick();
    checks++;
    if (bus.fire !== 8'h00 || bus.ack !== 8'h01) begin
      errors++; $display("FAIL single_no_regrant: fire %h ack %h expected 00 01", bus.fire, bus.ack);
    end
    bus.req = 8'h00;
    tick();
    checks++;
    if (bus.ack !== 8'h00) begin errors++; $display("FAIL single_ack_clear: got %h expected 00", bus.ack); end
    $display("test_single_fire: ack after req drop %h", bus.ack);
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req = 8'h22;
    bus.en  = 8'hFF;
    tick();
    checks++;
    if (bus.fire !== 8'h02) begin errors++; $display("FAIL rr_first: got %h expected 02", bus.fire); end
    tick();
    tick();
    checks++;
    if (bus.fire !== 8'h00) begin errors++; $display("FAIL rr_gap: got %h expected 00", bus.fire); end
    tick();
    checks++;
    if (bus.fire !== 8'h20 || bus.ack !== 8'h22) begin
      errors++; $display("FAIL rr_second: fire %h ack %h expected 20 22", bus.fire, bus.ack);
    end
    bus.req = 8'h00;
    tick();
    checks++;
    if (bus.ack !== 8'h00) begin errors++; $display("FAIL rr_ack_clear: got %h expected 00", bus.ack); end
    tick();
    bus.req = 8'h22;
    tick();
    checks++;
    if (bus.fire !== 8'h02) begin errors++; $display("FAIL rr_wrap: got %h expected 02", bus.fire); end
    $display("test_round_robin: regrant from ptr 6 fire %h", bus.fire);
  endtask

  task automatic test_enable_gating();
    do_reset();
    bus.req = 8'h08;
    bus.en  = 8'h00;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (bus.fire !== 8'h00 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL gate_blocked_%0d: fire %h busy %b expected 00 0", c, bus.fire, bus.busy);
      end
    end
    bus.en = 8'h08;
    tick();
    checks++;
    if (bus.fire !== 8'h08) begin errors++; $display("FAIL gate_open: got %h expected 08", bus.fire); end
    $display("test_enable_gating: fire after enable %h", bus.fire);
  endtask

  task automatic test_deadlock();
    do_reset();
    bus.req = 8'h10;
    bus.en  = 8'h00;
    for (int c = 0; c < 15; c++) tick();
    checks++;
    if (bus.deadlock !== 1'b0) begin errors++; $display("FAIL dl_early: got %b expected 0", bus.deadlock); end
    tick();
    checks++;
    if (bus.deadlock !== DL_EN) begin errors++; $display("FAIL dl_rise: got %b expected %b", bus.deadlock, DL_EN); end
    tick();
    checks++;
    if (bus.deadlock !== DL_EN) begin errors++; $display("FAIL dl_hold: got %b expected %b", bus.deadlock, DL_EN); end
    bus.en = 8'h10;
    tick();
    checks++;
    if (bus.fire !== 8'h10 || bus.deadlock !== 1'b0) begin
      errors++; $display("FAIL dl_clear: fire %h deadlock %b expected 10 0", bus.fire, bus.deadlock);
    end
    $display("test_deadlock: feature %b, after grant deadlock %b", DL_EN, bus.deadlock);
  endtask

  task automatic test_reset_mid_fire();
    do_reset();
    bus.req = 8'h04;
    bus.en  = 8'h04;
    tick();
    checks++;
    if (bus.fire !== 8'h04) begin errors++; $display("FAIL midrst_fire: got %h expected 04", bus.fire); end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.fire !== 8'h00 || bus.ack !== 8'h00 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL midrst_clear: fire %h ack %h busy %b expected 00 00 0", bus.fire, bus.ack, bus.busy);
    end
    reset   = 1'b0;
    bus.req = 8'h00;
    $display("test_reset_mid_fire: fire %h ack %h after reset", bus.fire, bus.ack);
  endtask

  task automatic test_back_to_back();
    logic [NT-1:0] exp_fire;
    do_reset();
    bus.req = 8'hFF;
    bus.en  = 8'hFF;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_fire = ((c % 3) == 1) ? (8'h01 << ((c - 1) / 3)) : 8'h00;
      checks++;
      if (bus.fire !== exp_fire) begin
        errors++; $display("FAIL b2b_cycle_%0d: got %h expected %h", c, bus.fire, exp_fire);
      end
    end
    checks++;
    if (bus.ack !== 8'h0F) begin errors++; $display("FAIL b2b_ack: got %h expected 0F", bus.ack); end
    bus.req = 8'h00;
    $display("test_back_to_back: ack after four grants %h", bus.ack);
  endtask

  initial begin
    bus.req = '0;
    bus.en  = '0;
    test_reset();
    test_single_fire();
    test_round_robin();
    test_enable_gating();
    test_deadlock();
    test_reset_mid_fire();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
